// File: rtl/risc_16bit_pkg.sv
// Shared encodings for the 16-bit RISC control unit and its datapath.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package risc_16bit_pkg;

  // Opcodes held in IR[15:12]
  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_LDC   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMPZ  = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Register-file write-mux select {s1,s0}
  localparam logic [1:0] RF_SEL_ALU   = 2'b00;
  localparam logic [1:0] RF_SEL_MEM   = 2'b01;
  localparam logic [1:0] RF_SEL_CONST = 2'b10;

  // ALU operation select
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Control FSM states
  typedef enum logic [3:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_LOAD,
    ST_STORE,
    ST_ADD,
    ST_LDC,
    ST_SUB,
    ST_JMPZ,
    ST_JMPZ_TAKE,
    ST_HALT
  } state_t;

endpackage

// File: rtl/risc_16bit_pc.sv
// Program counter: clear to RESET_PC, increment, or add a signed 8-bit offset.
// Latency: new PC visible one cycle after the control strobe.
// Backpressure: none; the PC holds whenever no control strobe is asserted.
module risc_16bit_pc #(
  parameter int             W        = 16,
  parameter logic [W-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_ld_off,
  input  logic [7:0]   i_off,
  output logic [W-1:0] o_pc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_pc;
  logic [W-1:0] w_off_sext;

  assign w_off_sext = {{(W-8){i_off[7]}}, i_off};

  // The offset is relative to the jump's own address; PC has already been bumped past it, hence -1.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_pc <= RESET_PC;
    end else if (i_inc) begin
      r_pc <= r_pc + ONE;
    end else if (i_ld_off) begin
      r_pc <= r_pc + w_off_sext - ONE;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/risc_16bit_control_unit.sv
// Multi-cycle control unit: fetch, decode and drive datapath controls; HALT op enabled by HALT_INSTR_EN.
// Latency: 3 cycles per instruction (2 for NOP, 4 for a taken jump); one instruction in flight.
// Backpressure: none; instruction ROM and register file are assumed to answer in the same cycle.
module risc_16bit_control_unit
  import risc_16bit_pkg::*;
#(
  parameter int           W        = 16,
  parameter int           DA_W     = 8,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    I_data,
  input  logic            RF_Rp_zero,
  output logic [W-1:0]    I_addr,
  output logic            I_rd,
  output logic [DA_W-1:0] D_addr,
  output logic            D_rd,
  output logic            D_wr,
  output logic [7:0]      RF_W_data,
  output logic            RF_s1,
  output logic            RF_s0,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_wr,
  output logic [3:0]      RF_Rp_addr,
  output logic            RF_Rp_rd,
  output logic [3:0]      RF_Rq_addr,
  output logic            RF_Rq_rd,
  output logic [2:0]      alu_s,
  output logic            halted
);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_ir;
  logic [W-1:0] w_pc;
  logic [3:0]   w_op;
  logic [3:0]   w_ra;
  logic [3:0]   w_rb;
  logic [3:0]   w_rc;
  logic [1:0]   w_rf_sel;
  logic         w_pc_clr;
  logic         w_pc_inc;
  logic         w_pc_ld;

  assign w_op = r_ir[W-1 -: 4];
  assign w_ra = r_ir[11:8];
  assign w_rb = r_ir[7:4];
  assign w_rc = r_ir[3:0];

  risc_16bit_pc #(
    .W        (W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_pc_clr),
    .i_inc    (w_pc_inc),
    .i_ld_off (w_pc_ld),
    .i_off    (r_ir[7:0]),
    .o_pc     (w_pc)
  );

  assign I_addr = w_pc;
  assign {RF_s1, RF_s0} = w_rf_sel;

  // State register and IR; IR only changes in INIT (clear) and FETCH (load).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT) begin
        r_ir <= '0;
      end else if (r_state == ST_FETCH) begin
        r_ir <= I_data;
      end
    end
  end

  // Next-state and per-state control decode; everything idles at zero unless the state claims it.
  always_comb begin
    w_next     = r_state;
    w_pc_clr   = 1'b0;
    w_pc_inc   = 1'b0;
    w_pc_ld    = 1'b0;
    w_rf_sel   = RF_SEL_ALU;
    I_rd       = 1'b0;
    D_addr     = '0;
    D_rd       = 1'b0;
    D_wr       = 1'b0;
    RF_W_data  = '0;
    RF_W_addr  = '0;
    RF_W_wr    = 1'b0;
    RF_Rp_addr = '0;
    RF_Rp_rd   = 1'b0;
    RF_Rq_addr = '0;
    RF_Rq_rd   = 1'b0;
    alu_s      = ALU_PASS;
    case (r_state)
      ST_INIT: begin
        w_pc_clr = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_FETCH: begin
        I_rd     = 1'b1;
        w_pc_inc = 1'b1;
        w_next   = ST_DECODE;
      end
      ST_DECODE: begin
        case (w_op)
          OP_LOAD:  w_next = ST_LOAD;
          OP_STORE: w_next = ST_STORE;
          OP_ADD:   w_next = ST_ADD;
          OP_LDC:   w_next = ST_LDC;
          OP_SUB:   w_next = ST_SUB;
          OP_JMPZ:  w_next = ST_JMPZ;
`ifdef HALT_INSTR_EN
          OP_HALT:  w_next = ST_HALT;
`else
          OP_HALT:  w_next = ST_FETCH;
`endif
          default:  w_next = ST_FETCH;
        endcase
      end
      ST_LOAD: begin
        D_addr    = r_ir[DA_W-1:0];
        D_rd      = 1'b1;
        w_rf_sel  = RF_SEL_MEM;
        RF_W_addr = w_ra;
        RF_W_wr   = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_STORE: begin
        D_addr     = r_ir[DA_W-1:0];
        D_wr       = 1'b1;
        RF_Rp_addr = w_ra;
        RF_Rp_rd   = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_ADD, ST_SUB: begin
        RF_Rp_addr = w_rb;
        RF_Rp_rd   = 1'b1;
        RF_Rq_addr = w_rc;
        RF_Rq_rd   = 1'b1;
        alu_s      = (r_state == ST_ADD) ? ALU_ADD : ALU_SUB;
        w_rf_sel   = RF_SEL_ALU;
        RF_W_addr  = w_ra;
        RF_W_wr    = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_LDC: begin
        RF_W_data = r_ir[7:0];
        w_rf_sel  = RF_SEL_CONST;
        RF_W_addr = w_ra;
        RF_W_wr   = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_JMPZ: begin
        RF_Rp_addr = w_ra;
        RF_Rp_rd   = 1'b1;
        w_next     = RF_Rp_zero ? ST_JMPZ_TAKE : ST_FETCH;
      end
      ST_JMPZ_TAKE: begin
        w_pc_ld = 1'b1;
        w_next  = ST_FETCH;
      end
`ifdef HALT_INSTR_EN
      ST_HALT: begin
        w_next = ST_HALT;
      end
`endif
      default: begin
        w_next = ST_INIT;
      end
    endcase
  end

`ifdef HALT_INSTR_EN
  assign halted = (r_state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
